// File: rtl/fetch_sequencer.sv
// fetch_sequencer
//   Owns the architectural PC and sequences instruction fetch:
//   request -> wait for ack -> hold instruction for decode -> load next PC.
//   Next-PC choices: PC+1, flag-qualified jump, call (RAS push), return (RAS pop).
//   A redirect forces a PC load from any non-IDLE state and beats everything else.
//
// Optional feature macro: PERF_CNT_EN
//   When defined, adds o_retire_cnt / o_taken_cnt performance counters.
//
// Ports
//   clk, rst              clock (rising edge), async active-high reset
//   o_imem_req            fetch request (FETCH state)
//   o_imem_addr           fetch address, always equals o_pc
//   i_imem_ack            memory returned the instruction this cycle
//   o_instr_valid         instruction held for the decoder (ISSUE state)
//   i_dec_ready           decoder consumes the instruction (retire strobe)
//   i_br_valid            retiring instruction is a control transfer
//   i_br_type             00 JMP/NOC, 01 RET, 10 JGT/IGT, 11 JLS/ILS
//   i_br_call             taken jump also pushes the return address
//   i_jta                 jump target address
//   i_noc, i_igt, i_ils   condition flags
//   i_halt                stop after loading the next PC
//   i_resume              leave HALT
//   i_redirect_valid      forced PC load (exception/flush)
//   i_redirect_addr       redirect target
//   o_pc                  current PC
//   o_ras_ovf, o_ras_unf  sticky RAS overflow / underflow
//   o_retire_cnt          (PERF_CNT_EN) non-suppressed retires
//   o_taken_cnt           (PERF_CNT_EN) retires that loaded jta or a RAS value

module fetch_sequencer #(
  parameter int             AW           = 22,
  parameter int             RAS_DEPTH    = 4,
  parameter logic [AW-1:0]  RESET_VECTOR = '0
) (
  input  logic          clk,
  input  logic          rst,
  output logic          o_imem_req,
  output logic [AW-1:0] o_imem_addr,
  input  logic          i_imem_ack,
  output logic          o_instr_valid,
  input  logic          i_dec_ready,
  input  logic          i_br_valid,
  input  logic [1:0]    i_br_type,
  input  logic          i_br_call,
  input  logic [AW-1:0] i_jta,
  input  logic          i_noc,
  input  logic          i_igt,
  input  logic          i_ils,
  input  logic          i_halt,
  input  logic          i_resume,
  input  logic          i_redirect_valid,
  input  logic [AW-1:0] i_redirect_addr,
  output logic [AW-1:0] o_pc,
  output logic          o_ras_ovf,
  output logic          o_ras_unf
`ifdef PERF_CNT_EN
  ,
  output logic [31:0]   o_retire_cnt,
  output logic [31:0]   o_taken_cnt
`endif
);

  localparam int CW = $clog2(RAS_DEPTH) + 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_ISSUE = 2'd2,
    S_HALT  = 2'd3
  } state_t;

  state_t        r_state;
  state_t        w_state_nxt;
  logic [AW-1:0] r_pc;
  logic [AW-1:0] w_pc_nxt;
  logic [AW-1:0] w_pc_inc;
  logic [AW-1:0] r_ras [RAS_DEPTH];
  logic [CW-1:0] r_ras_cnt;
  logic [CW-2:0] w_top_idx;
  logic          r_ras_ovf;
  logic          r_ras_unf;

  logic w_redirect;
  logic w_retire;
  logic w_cond;
  logic w_is_ret;
  logic w_taken;
  logic w_push;
  logic w_pop;
  logic w_ras_full;
  logic w_ras_empty;

  assign w_pc_inc    = r_pc + AW'(1);
  assign w_ras_full  = (r_ras_cnt == CW'(RAS_DEPTH));
  assign w_ras_empty = (r_ras_cnt == '0);
  // When full the low bits wrap to 0, so "minus one" still lands on DEPTH-1.
  assign w_top_idx   = r_ras_cnt[CW-2:0] - 1'b1;

  // A redirect in the same cycle as a retire kills the retire entirely.
  assign w_redirect = i_redirect_valid && (r_state != S_IDLE);
  assign w_retire   = (r_state == S_ISSUE) && i_dec_ready && !w_redirect;

  always_comb begin
    w_cond = 1'b0;
    case (i_br_type)
      2'b00:   w_cond = i_noc;
      2'b10:   w_cond = i_igt;
      2'b11:   w_cond = i_ils;
      default: w_cond = 1'b0;
    endcase
  end

  assign w_is_ret = w_retire && i_br_valid && (i_br_type == 2'b01);
  assign w_taken  = w_retire && i_br_valid && w_cond;
  assign w_push   = w_taken && i_br_call;
  assign w_pop    = w_is_ret && !w_ras_empty;

  always_comb begin
    w_state_nxt = r_state;
    w_pc_nxt    = r_pc;
    if (w_redirect) begin
      w_state_nxt = S_FETCH;
      w_pc_nxt    = i_redirect_addr;
    end else begin
      case (r_state)
        S_IDLE:  w_state_nxt = S_FETCH;
        S_FETCH: if (i_imem_ack) w_state_nxt = S_ISSUE;
        S_ISSUE: begin
          if (w_retire) begin
            if (w_taken)    w_pc_nxt = i_jta;
            else if (w_pop) w_pc_nxt = r_ras[w_top_idx];
            else            w_pc_nxt = w_pc_inc;
            w_state_nxt = i_halt ? S_HALT : S_FETCH;
          end
        end
        S_HALT:  if (i_resume) w_state_nxt = S_FETCH;
        default: w_state_nxt = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_pc    <= RESET_VECTOR;
    end else begin
      r_state <= w_state_nxt;
      r_pc    <= w_pc_nxt;
    end
  end

  // RAS: entry 0 is the oldest; a push when full shifts everything down one
  // slot, dropping the oldest return address.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < RAS_DEPTH; i++) r_ras[i] <= '0;
      r_ras_cnt <= '0;
      r_ras_ovf <= 1'b0;
      r_ras_unf <= 1'b0;
    end else begin
      if (w_push) begin
        if (w_ras_full) begin
          for (int i = 0; i < RAS_DEPTH - 1; i++) r_ras[i] <= r_ras[i+1];
          r_ras[RAS_DEPTH-1] <= w_pc_inc;
          r_ras_ovf          <= 1'b1;
        end else begin
          r_ras[r_ras_cnt[CW-2:0]] <= w_pc_inc;
          r_ras_cnt                <= r_ras_cnt + CW'(1);
        end
      end else if (w_pop) begin
        r_ras_cnt <= r_ras_cnt - CW'(1);
      end
      if (w_is_ret && w_ras_empty) r_ras_unf <= 1'b1;
    end
  end

`ifdef PERF_CNT_EN
  logic [31:0] r_retire_cnt;
  logic [31:0] r_taken_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_retire_cnt <= '0;
      r_taken_cnt  <= '0;
    end else begin
      if (w_retire)          r_retire_cnt <= r_retire_cnt + 32'd1;
      if (w_taken || w_pop)  r_taken_cnt  <= r_taken_cnt + 32'd1;
    end
  end

  assign o_retire_cnt = r_retire_cnt;
  assign o_taken_cnt  = r_taken_cnt;
`endif

  assign o_imem_req    = (r_state == S_FETCH);
  assign o_instr_valid = (r_state == S_ISSUE);
  assign o_imem_addr   = r_pc;
  assign o_pc          = r_pc;
  assign o_ras_ovf     = r_ras_ovf;
  assign o_ras_unf     = r_ras_unf;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Testbench for fetch_sequencer: directed scenarios followed by random traffic,
// all checked every cycle against a behavioural model of the sequencer.

module tb_fetch_sequencer;

  localparam int AW    = 22;
  localparam int DEPTH = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          imem_req;
  logic [AW-1:0] imem_addr;
  logic          imem_ack;
  logic          instr_valid;
  logic          dec_ready;
  logic          br_valid;
  logic [1:0]    br_type;
  logic          br_call;
  logic [AW-1:0] jta;
  logic          noc, igt, ils;
  logic          halt, resume;
  logic          redirect_valid;
  logic [AW-1:0] redirect_addr;
  logic [AW-1:0] pc;
  logic          ras_ovf, ras_unf;
`ifdef PERF_CNT_EN
  logic [31:0]   retire_cnt, taken_cnt;
`endif

  always #5 clk = ~clk;

  fetch_sequencer #(.AW(AW), .RAS_DEPTH(DEPTH), .RESET_VECTOR('0)) dut (
    .clk(clk), .rst(rst),
    .o_imem_req(imem_req), .o_imem_addr(imem_addr), .i_imem_ack(imem_ack),
    .o_instr_valid(instr_valid), .i_dec_ready(dec_ready),
    .i_br_valid(br_valid), .i_br_type(br_type), .i_br_call(br_call), .i_jta(jta),
    .i_noc(noc), .i_igt(igt), .i_ils(ils),
    .i_halt(halt), .i_resume(resume),
    .i_redirect_valid(redirect_valid), .i_redirect_addr(redirect_addr),
    .o_pc(pc), .o_ras_ovf(ras_ovf), .o_ras_unf(ras_unf)
`ifdef PERF_CNT_EN
    , .o_retire_cnt(retire_cnt), .o_taken_cnt(taken_cnt)
`endif
  );

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  localparam int PH_START = 0;  // first cycle after reset
  localparam int PH_WAIT  = 1;  // requesting memory
  localparam int PH_HOLD  = 2;  // instruction offered to decoder
  localparam int PH_STOP  = 3;  // halted

  int            m_phase;
  logic [AW-1:0] m_pc;
  logic [AW-1:0] m_ras[$];
  logic          m_ovf, m_unf;
  logic [31:0]   m_ret, m_tak;
  logic [AW-1:0] m_link;
  logic          m_flag;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_phase = PH_START;
      m_pc    = '0;
      m_ras.delete();
      m_ovf   = 1'b0;
      m_unf   = 1'b0;
      m_ret   = '0;
      m_tak   = '0;
    end else if (redirect_valid && m_phase != PH_START) begin
      m_pc    = redirect_addr;
      m_phase = PH_WAIT;
    end else begin
      case (m_phase)
        PH_START: m_phase = PH_WAIT;
        PH_WAIT:  if (imem_ack) m_phase = PH_HOLD;
        PH_HOLD: if (dec_ready) begin
          m_link = m_pc + 1;
          m_flag = (br_type == 2'd0) ? noc : (br_type == 2'd2) ? igt :
                   (br_type == 2'd3) ? ils : 1'b0;
          m_ret  = m_ret + 1;
          if (br_valid && br_type == 2'd1) begin
            if (m_ras.size() > 0) begin
              m_pc  = m_ras.pop_back();
              m_tak = m_tak + 1;
            end else begin
              m_pc  = m_link;
              m_unf = 1'b1;
            end
          end else if (br_valid && m_flag) begin
            if (br_call) begin
              if (m_ras.size() == DEPTH) begin
                void'(m_ras.pop_front());
                m_ovf = 1'b1;
              end
              m_ras.push_back(m_link);
            end
            m_pc  = jta;
            m_tak = m_tak + 1;
          end else begin
            m_pc = m_link;
          end
          m_phase = halt ? PH_STOP : PH_WAIT;
        end
        default: if (resume) m_phase = PH_WAIT;
      endcase
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    chk("imem_req",    {31'd0, imem_req},    {31'd0, m_phase == PH_WAIT});
    chk("instr_valid", {31'd0, instr_valid}, {31'd0, m_phase == PH_HOLD});
    chk("imem_addr",   imem_addr, m_pc);
    chk("pc",          pc,        m_pc);
    chk("ras_ovf",     {31'd0, ras_ovf}, {31'd0, m_ovf});
    chk("ras_unf",     {31'd0, ras_unf}, {31'd0, m_unf});
`ifdef PERF_CNT_EN
    chk("retire_cnt",  retire_cnt, m_ret);
    chk("taken_cnt",   taken_cnt,  m_tak);
`endif
  end

  // ---------------- stimulus helpers ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    imem_ack = 0; dec_ready = 0; br_valid = 0; br_type = 0; br_call = 0;
    jta = '0; noc = 0; igt = 0; ils = 0; halt = 0; resume = 0;
    redirect_valid = 0; redirect_addr = '0;
  endtask

  task automatic wait_req(input logic [AW-1:0] exp_addr);
    int t = 0;
    while (!imem_req && t < 40) begin
      step();
      t++;
    end
    chk("req_timeout", {31'd0, imem_req}, 32'd1);
    chk("fetch_addr", imem_addr, exp_addr);
  endtask

  // One instruction: memory answers one cycle after the request, decoder
  // retires immediately with the given control-transfer fields.
  task automatic instr(input logic [AW-1:0] exp_addr, input logic bv,
                       input logic [1:0] bt, input logic call,
                       input logic [AW-1:0] tgt, input logic fl, input logic h);
    wait_req(exp_addr);
    step();
    imem_ack = 1;
    step();
    imem_ack = 0;
    chk("issue_valid", {31'd0, instr_valid}, 32'd1);
    dec_ready = 1; br_valid = bv; br_type = bt; br_call = call; jta = tgt;
    noc = fl; igt = fl; ils = fl; halt = h;
    step();
    clear_inputs();
  endtask

  task automatic redirect_on_ack(input logic [AW-1:0] exp_addr, input logic [AW-1:0] tgt);
    wait_req(exp_addr);
    imem_ack = 1; redirect_valid = 1; redirect_addr = tgt;
    step();
    clear_inputs();
  endtask

  initial begin
    clear_inputs();
    rst = 1;
    step();
    step();
    chk("rst_req",   {31'd0, imem_req},    32'd0);
    chk("rst_valid", {31'd0, instr_valid}, 32'd0);
    chk("rst_pc",    pc, '0);
    rst = 0;

    // sequential fetch 0..4
    for (int a = 0; a < 5; a++) instr(AW'(a), 0, 2'd0, 0, '0, 0, 0);
    // JGT taken / not taken at pc=5
    instr(22'h5,   1, 2'd2, 0, 22'h100, 1, 0);
    instr(22'h100, 1, 2'd0, 0, 22'h5,   1, 0);
    instr(22'h5,   1, 2'd2, 0, 22'h100, 0, 0);
    instr(22'h6,   1, 2'd0, 0, 22'h10,  1, 0);
    // call at 0x10, return at 0x205
    instr(22'h10,  1, 2'd0, 1, 22'h200, 1, 0);
    for (int a = 'h200; a < 'h205; a++) instr(AW'(a), 0, 2'd0, 0, '0, 0, 0);
    instr(22'h205, 1, 2'd1, 0, '0, 0, 0);
    // five nested calls overflow a 4-deep RAS
    instr(22'h11,  1, 2'd0, 1, 22'h300, 1, 0);
    instr(22'h300, 1, 2'd3, 1, 22'h400, 1, 0);
    instr(22'h400, 1, 2'd2, 1, 22'h500, 1, 0);
    instr(22'h500, 1, 2'd0, 1, 22'h600, 1, 0);
    chk("ovf_before", {31'd0, ras_ovf}, 32'd0);
    instr(22'h600, 1, 2'd0, 1, 22'h700, 1, 0);
    chk("ovf_after", {31'd0, ras_ovf}, 32'd1);
    instr(22'h700, 1, 2'd1, 0, '0, 0, 0);
    instr(22'h601, 1, 2'd1, 0, '0, 0, 0);
    instr(22'h501, 1, 2'd1, 0, '0, 0, 0);
    instr(22'h401, 1, 2'd1, 0, '0, 0, 0);
    chk("unf_before", {31'd0, ras_unf}, 32'd0);
    instr(22'h301, 1, 2'd1, 0, '0, 0, 0);
    chk("unf_after", {31'd0, ras_unf}, 32'd1);
    // wrap at the top of the address space
    redirect_on_ack(22'h302, 22'h3FFFFF);
    instr(22'h3FFFFF, 0, 2'd0, 0, '0, 0, 0);
    // redirect with same-cycle ack
    redirect_on_ack(22'h000000, 22'h40);
    // redirect during a retiring call: no push, no retire
    wait_req(22'h40);
    step();
    imem_ack = 1;
    step();
    imem_ack = 0;
    dec_ready = 1; br_valid = 1; br_type = 2'd0; br_call = 1; noc = 1; jta = 22'h999;
    redirect_valid = 1; redirect_addr = 22'h80;
    step();
    clear_inputs();
    instr(22'h80, 1, 2'd1, 0, '0, 0, 0);
    // halt and resume
    instr(22'h81, 0, 2'd0, 0, '0, 0, 1);
    step();
    step();
    chk("halt_req",   {31'd0, imem_req},    32'd0);
    chk("halt_valid", {31'd0, instr_valid}, 32'd0);
    chk("halt_pc",    pc, 22'h82);
    resume = 1;
    step();
    resume = 0;
    wait_req(22'h82);

    // random traffic
    for (int c = 0; c < 4000; c++) begin
      imem_ack       = $urandom_range(0, 1);
      dec_ready      = $urandom_range(0, 1);
      br_valid       = $urandom_range(0, 1);
      br_type        = 2'($urandom_range(0, 3));
      br_call        = $urandom_range(0, 1);
      jta            = AW'($urandom);
      noc            = $urandom_range(0, 1);
      igt            = $urandom_range(0, 1);
      ils            = $urandom_range(0, 1);
      halt           = ($urandom_range(0, 7) == 0);
      resume         = ($urandom_range(0, 3) == 0);
      redirect_valid = ($urandom_range(0, 19) == 0);
      redirect_addr  = ($urandom_range(0, 3) == 0) ? 22'h3FFFFF : AW'($urandom);
      step();
    end
    clear_inputs();
    step();
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fetch_sequencer.md
Name: fetch_sequencer

Overview:
- Owns the architectural PC register and sequences instruction fetch: issues a request, waits for the memory acknowledge, holds the instruction for decode, then computes and loads the next PC.
- Next-PC selection is built in: sequential increment, flag-qualified jump, call with return-address stack (RAS) push, and return via RAS pop.
- Sits between instruction memory and the decoder; replaces the free-running PC+1 path with a handshaked, stallable, redirectable sequencer.

Parameters:
- AW, 22, PC/address width.
- RAS_DEPTH, 4, return-address stack entries (power of 2, ≥2).
- RESET_VECTOR, 0, PC value loaded at reset.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- imem_req  out  1  fetch request.
- imem_addr  out  AW  fetch address (= PC).
- imem_ack  in  1  memory returned instruction this cycle.
- instr_valid  out  1  fetched instruction held for decoder.
- dec_ready  in  1  decoder consumes instruction (retire strobe when instr_valid=1).
- br_valid  in  1  retiring instruction is a control transfer (sampled at retire).
- br_type  in  2  00 JMP if NOC, 01 RET, 10 JGT if IGT, 11 JLS if ILS.
- br_call  in  1  taken br_type 00/10/11 also pushes PC+1 to RAS.
- jta  in  AW  jump target address.
- noc, igt, ils  in  1 each  condition flags, sampled at retire.
- halt  in  1  at retire: stop after loading next PC.
- resume  in  1  leave HALT.
- redirect_valid  in  1  forced PC load (exception/flush), highest priority.
- redirect_addr  in  AW  redirect target.
- pc  out  AW  current PC.
- ras_ovf, ras_unf  out  1 each  sticky overflow/underflow flags.

Behaviour:
- Reset (async): state=IDLE, pc=RESET_VECTOR, imem_req=0, instr_valid=0, RAS empty (count=0), ras_ovf=0, ras_unf=0. imem_addr always equals pc.
- States: IDLE, FETCH, ISSUE, HALT.
- IDLE: one cycle after reset release -> FETCH.
- FETCH: imem_req=1, address stable. On imem_ack -> ISSUE. Min latency request-to-instr_valid = 1 cycle after ack.
- ISSUE: instr_valid=1, held until dec_ready. Retire = instr_valid & dec_ready; at retire, next-PC rules:
  - br_valid=0 -> pc+1.
  - type 00/10/11 with flag (noc/igt/ils) =1 -> jta; flag =0 -> pc+1.
  - type 01 -> RAS top, pop; RAS empty -> pc+1, set ras_unf.
  - Taken and br_call=1 -> push pc+1 (the return address). Full -> oldest entry discarded, push proceeds, set ras_ovf. br_call ignored for RET and for not-taken branches.
  - After retire -> HALT if halt=1, else FETCH.
- HALT: imem_req=0, instr_valid=0; resume -> FETCH at held pc.
- redirect_valid in any non-IDLE state: pc<=redirect_addr, -> FETCH next cycle, instr_valid drops, imem_ack in that cycle discarded, RAS unchanged, same-cycle retire suppressed (no push/pop).
- All PC arithmetic is modulo 2^AW: pc=all-ones + 1 wraps to 0. jta is used unmodified.
- Sticky flags clear only on reset.

Optional Feature:
- PERF_CNT_EN.
- Defined: adds outputs retire_cnt[31:0] and taken_cnt[31:0].
  - retire_cnt increments on each non-suppressed retire.
  - taken_cnt increments on each retire that loads jta or a RAS value.
  - Both reset to 0 and wrap at 2^32.
- Undefined: outputs and counters absent; no other behaviour changes.

Test Plan:
- Reset, then ack every fetch, dec_ready=1, br_valid=0 -> imem_addr sequence 0,1,2,3; one retire per 3 cycles.
- At pc=5: br_valid=1, type=10, igt=1, jta=0x100 -> next fetch 0x100. Repeat with igt=0 -> next fetch 6.
- Call at pc=0x10 (type 00, noc=1, br_call=1, jta=0x200); later RET at 0x205 -> fetch 0x11, RAS count back to 0.
- 5 calls with RAS_DEPTH=4 -> ras_ovf=1. 5 RETs -> four return addresses, newest first. Fifth RET -> pc+1 and ras_unf=1.
- pc=0x3FFFFF, br_valid=0 -> next imem_addr 0x000000.
- redirect_valid with redirect_addr=0x40 in the same cycle as imem_ack -> ack ignored, next fetch 0x40, no retire counted. halt at retire -> HALT; resume -> fetch resumes at stored pc.
